// File: rtl/mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mac_tx_arbiter
//
// Frame-level round-robin arbiter that shares the MAC transmit AXI-Stream input
// among NUM_PORTS user requesters. Once a port is granted it owns the MAC until
// its tlast beat is accepted, so frames from different ports never interleave.
// After each frame the arbiter returns to IDLE for at least one cycle, optionally
// preceded by GAP_CYCLES forced idle cycles.
//
// Parameters:
//   NUM_PORTS        number of requesting slave ports (2..8)
//   AXIS_DATA_WIDTH  data width per port and on the master side
//   AXIS_DATA_BYTES  tkeep width per port
//   GAP_CYCLES       idle cycles forced after each tlast handshake (0..15)
//
// Ports:
//   mac_clk, mac_rst          clock, synchronous active-high reset
//   s_axis_*                  packed per-port slave streams, port p at [p*W +: W]
//   m_axis_*                  master stream towards the MAC TX AXIS slave
//   port_enable               per-port request mask, only looked at when arbitrating
//   grant                     registered one-hot owner, 0 when nobody owns the MAC
//   busy                      high while transferring a frame or in the idle gap
//
// Optional feature (macro TX_ARB_STATS_EN):
//   stats_clear               clears all frame counters on the next edge
//   frame_count               16-bit per-port count of accepted tlast beats
// -----------------------------------------------------------------------------
module mac_tx_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
    parameter int GAP_CYCLES      = 0
) (
    input  logic                                   mac_clk,
    input  logic                                   mac_rst,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0]   s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                   s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                   s_axis_tlast,
    output logic [NUM_PORTS-1:0]                   s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [AXIS_DATA_BYTES-1:0]             m_axis_tkeep,
    output logic                                   m_axis_tvalid,
    output logic                                   m_axis_tlast,
    input  logic                                   m_axis_tready,
    input  logic [NUM_PORTS-1:0]                   port_enable,
    output logic [NUM_PORTS-1:0]                   grant,
    output logic                                   busy
`ifdef TX_ARB_STATS_EN
    ,
    input  logic                                   stats_clear,
    output logic [NUM_PORTS*16-1:0]                frame_count
`endif
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    generate
        if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_num_ports
            $error("mac_tx_arbiter: NUM_PORTS must be in 2..8");
        end
        if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap_cycles
            $error("mac_tx_arbiter: GAP_CYCLES must be in 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [PW-1:0]        last_q, last_d;
    logic [3:0]           gap_cnt_q, gap_cnt_d;

    // Unpacked views of the packed slave buses.
    logic [AXIS_DATA_WIDTH-1:0] tdata_arr [NUM_PORTS];
    logic [AXIS_DATA_BYTES-1:0] tkeep_arr [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign tdata_arr[gi] = s_axis_tdata[gi*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
            assign tkeep_arr[gi] = s_axis_tkeep[gi*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
        end
    endgenerate

    // While in XFER, last_q always holds the owner index, so it doubles as
    // the pass-through mux select.
    logic [AXIS_DATA_WIDTH-1:0] sel_tdata;
    logic [AXIS_DATA_BYTES-1:0] sel_tkeep;
    logic                       sel_tvalid;
    logic                       sel_tlast;
    logic                       last_hs;

    assign sel_tdata  = tdata_arr[last_q];
    assign sel_tkeep  = tkeep_arr[last_q];
    assign sel_tvalid = s_axis_tvalid[last_q];
    assign sel_tlast  = s_axis_tlast[last_q];
    assign last_hs    = (state_q == ST_XFER) && sel_tvalid && m_axis_tready && sel_tlast;

    // Round-robin pick: first requesting port after the last one served.
    logic [NUM_PORTS-1:0] req;
    logic [PW-1:0]        winner;
    logic                 found;
    logic [PW-1:0]        idx;

    assign req = s_axis_tvalid & port_enable;

    always_comb begin
        winner = last_q;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = PW'((int'(last_q) + i) % NUM_PORTS);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        gap_cnt_d     = gap_cnt_q;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = NUM_PORTS'(1) << winner;
                    last_d  = winner;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                m_axis_tdata  = sel_tdata;
                m_axis_tkeep  = sel_tkeep;
                m_axis_tvalid = sel_tvalid;
                m_axis_tlast  = sel_tlast;
                s_axis_tready = grant_q & {NUM_PORTS{m_axis_tready}};
                if (last_hs) begin
                    grant_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = 4'(GAP_CYCLES - 1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= PW'(NUM_PORTS - 1);
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

`ifdef TX_ARB_STATS_EN
    logic [15:0] frame_cnt_q [NUM_PORTS];
    logic [15:0] frame_cnt_d [NUM_PORTS];

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
            // Clear takes priority over a coincident tlast.
            always_comb begin
                frame_cnt_d[gi] = frame_cnt_q[gi];
                if (stats_clear) begin
                    frame_cnt_d[gi] = '0;
                end else if (last_hs && grant_q[gi]) begin
                    frame_cnt_d[gi] = frame_cnt_q[gi] + 16'd1;
                end
            end

            always_ff @(posedge mac_clk) begin
                if (mac_rst) begin
                    frame_cnt_q[gi] <= '0;
                end else begin
                    frame_cnt_q[gi] <= frame_cnt_d[gi];
                end
            end

            assign frame_count[gi*16 +: 16] = frame_cnt_q[gi];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mac_tx_arbiter
//
// Directed bench for mac_tx_arbiter. Two instances share the same inputs:
// dut_a uses GAP_CYCLES=0, dut_b uses GAP_CYCLES=4. A small source model per
// port produces frames whose beats carry {port, frame number, beat number} in
// tdata, so every accepted beat identifies its origin. Expected values are
// hand-written tables or timeline formulas.
// -----------------------------------------------------------------------------
module tb_mac_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         mac_rst;
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep;
    logic [3:0]   s_tvalid;
    logic [3:0]   s_tlast;
    logic [3:0]   port_en;
    logic         m_rdy;

    logic [3:0]   a_s_tready, b_s_tready;
    logic [31:0]  a_m_tdata, b_m_tdata;
    logic [3:0]   a_m_tkeep, b_m_tkeep;
    logic         a_m_tvalid, b_m_tvalid;
    logic         a_m_tlast, b_m_tlast;
    logic [3:0]   a_grant, b_grant;
    logic         a_busy, b_busy;

`ifdef TX_ARB_STATS_EN
    logic         stats_clear;
    logic [63:0]  a_frame_count, b_frame_count;
`endif

    mac_tx_arbiter #(
        .NUM_PORTS(4), .AXIS_DATA_WIDTH(32), .AXIS_DATA_BYTES(4), .GAP_CYCLES(0)
    ) dut_a (
        .mac_clk      (clk),
        .mac_rst      (mac_rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(a_s_tready),
        .m_axis_tdata (a_m_tdata),
        .m_axis_tkeep (a_m_tkeep),
        .m_axis_tvalid(a_m_tvalid),
        .m_axis_tlast (a_m_tlast),
        .m_axis_tready(m_rdy),
        .port_enable  (port_en),
        .grant        (a_grant),
        .busy         (a_busy)
`ifdef TX_ARB_STATS_EN
        ,
        .stats_clear  (stats_clear),
        .frame_count  (a_frame_count)
`endif
    );

    mac_tx_arbiter #(
        .NUM_PORTS(4), .AXIS_DATA_WIDTH(32), .AXIS_DATA_BYTES(4), .GAP_CYCLES(4)
    ) dut_b (
        .mac_clk      (clk),
        .mac_rst      (mac_rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(b_s_tready),
        .m_axis_tdata (b_m_tdata),
        .m_axis_tkeep (b_m_tkeep),
        .m_axis_tvalid(b_m_tvalid),
        .m_axis_tlast (b_m_tlast),
        .m_axis_tready(m_rdy),
        .port_enable  (port_en),
        .grant        (b_grant),
        .busy         (b_busy)
`ifdef TX_ARB_STATS_EN
        ,
        .stats_clear  (stats_clear),
        .frame_count  (b_frame_count)
`endif
    );

    // Source model state
    int   beat   [4];
    int   frame  [4];
    int   left   [4];
    int   flen   [4];
    logic hold   [4];
    logic sel_b;

    // Outputs of the selected DUT, sampled just before the clock edge
    logic [31:0] o_tdata;
    logic [3:0]  o_tkeep;
    logic        o_tvalid;
    logic        o_tlast;
    logic [3:0]  o_s_tready;
    logic [3:0]  o_grant;
    logic        o_busy;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < 4; p++) begin
            s_tvalid[p]         = (left[p] > 0) && !hold[p];
            s_tlast[p]          = (beat[p] == flen[p] - 1);
            s_tdata[p*32 +: 32] = {4'(p), 12'(frame[p]), 16'(beat[p])};
            s_tkeep[p*4 +: 4]   = 4'hF >> (beat[p] % 4);
        end
    endtask

    // One clock cycle: drive, sample the selected DUT, take the edge, advance
    // the sources that handshook.
    task automatic step();
        logic [3:0] hs;
        drive_inputs();
        #1;
        if (sel_b) begin
            o_tdata = b_m_tdata;  o_tkeep = b_m_tkeep;  o_tvalid = b_m_tvalid;
            o_tlast = b_m_tlast;  o_s_tready = b_s_tready;
            o_grant = b_grant;    o_busy = b_busy;
        end else begin
            o_tdata = a_m_tdata;  o_tkeep = a_m_tkeep;  o_tvalid = a_m_tvalid;
            o_tlast = a_m_tlast;  o_s_tready = a_s_tready;
            o_grant = a_grant;    o_busy = a_busy;
        end
        hs = s_tvalid & o_s_tready;
        if (o_tvalid && m_rdy && !mac_rst)
            $display("beat grant=%b data=%h keep=%b last=%0d", o_grant, o_tdata, o_tkeep, o_tlast);
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (hs[p]) begin
                if (beat[p] == flen[p] - 1) begin
                    beat[p]  = 0;
                    frame[p] = frame[p] + 1;
                    left[p]  = left[p] - 1;
                end else begin
                    beat[p] = beat[p] + 1;
                end
            end
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < 4; p++) begin
            beat[p] = 0; frame[p] = 0; left[p] = 0; flen[p] = 1; hold[p] = 1'b0;
        end
        m_rdy   = 1'b1;
        port_en = 4'hF;
        sel_b   = 1'b0;
    endtask

    task automatic do_reset();
        mac_rst = 1'b1;
        step();
        step();
        mac_rst = 1'b0;
    endtask

    logic [3:0]  g4   [17] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                               4'h8, 4'h8, 4'h8, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
    logic        tr2  [9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int          acc2 [9]  = '{-1, 0, -1, 1, 2, -1, 3, 4, -1};
    logic [3:0]  keep2[5]  = '{4'hF, 4'h7, 4'h3, 4'h1, 4'hF};
    logic [3:0]  g5   [9]  = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
    logic        bz5  [9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        v5   [9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        mac_rst  = 1'b1;
        s_tdata  = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0;
`ifdef TX_ARB_STATS_EN
        stats_clear = 1'b0;
`endif
        model_clear();
        @(posedge clk);
        #1;

        // ---- Test 1: reset state, then 4-port round robin, 3-beat frames
        for (int p = 0; p < 4; p++) begin
            flen[p] = 3; left[p] = 1000;
        end
        mac_rst = 1'b1;
        step();
        step();
        check_eq("rst grant",   32'(o_grant),    32'h0);
        check_eq("rst busy",    32'(o_busy),     32'h0);
        check_eq("rst tvalid",  32'(o_tvalid),   32'h0);
        check_eq("rst tlast",   32'(o_tlast),    32'h0);
        check_eq("rst tdata",   o_tdata,         32'h0);
        check_eq("rst tkeep",   32'(o_tkeep),    32'h0);
        check_eq("rst s_tready", 32'(o_s_tready), 32'h0);
        mac_rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            int port;
            step();
            port = ((c - 1) / 4) % 4;
            if (c % 4 == 0) begin
                check_eq($sformatf("t1 grant c%0d", c),  32'(o_grant),  32'h0);
                check_eq($sformatf("t1 tvalid c%0d", c), 32'(o_tvalid), 32'h0);
            end else begin
                check_eq($sformatf("t1 grant c%0d", c),  32'(o_grant),  32'(4'b1 << port));
                check_eq($sformatf("t1 tready c%0d", c), 32'(o_s_tready), 32'(4'b1 << port));
                check_eq($sformatf("t1 tdata c%0d", c),  o_tdata,
                         {4'(port), 12'((c - 1) / 16), 16'((c - 1) % 4)});
                check_eq($sformatf("t1 tlast c%0d", c),  32'(o_tlast), 32'((c - 1) % 4 == 2));
            end
        end

        // ---- Test 2: port 2 alone, 5 beats, MAC stalls beats 2 and 4
        model_clear();
        flen[2] = 5; left[2] = 1;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            m_rdy = tr2[c];
            step();
            check_eq($sformatf("t2 s_tready c%0d", c), 32'(o_s_tready),
                     (c >= 1 && c <= 7 && tr2[c]) ? 32'h4 : 32'h0);
            if (c >= 1 && c <= 7)
                check_eq($sformatf("t2 tvalid c%0d", c), 32'(o_tvalid), 32'h1);
            if (acc2[c] >= 0) begin
                check_eq($sformatf("t2 tdata c%0d", c), o_tdata, {4'd2, 12'd0, 16'(acc2[c])});
                check_eq($sformatf("t2 tkeep c%0d", c), 32'(o_tkeep), 32'(keep2[acc2[c]]));
                check_eq($sformatf("t2 tlast c%0d", c), 32'(o_tlast), 32'(acc2[c] == 4));
            end
        end
        m_rdy = 1'b1;

        // ---- Test 3: port 1 bubbles mid-frame while port 3 waits; reset mid-frame
        model_clear();
        flen[1] = 4; left[1] = 1;
        flen[3] = 4; left[3] = 1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            hold[1] = (c >= 3 && c <= 5);
            step();
            if (c >= 1 && c <= 7)
                check_eq($sformatf("t3 grant c%0d", c), 32'(o_grant), 32'h2);
            if (c >= 3 && c <= 5)
                check_eq($sformatf("t3 bubble tvalid c%0d", c), 32'(o_tvalid), 32'h0);
        end
        check_eq("t3 grant c9", 32'(o_grant), 32'h8);
        check_eq("t3 tdata c9", o_tdata, 32'h3000_0000);
        mac_rst = 1'b1;
        step();
        step();
        check_eq("t3 midrst grant",  32'(o_grant),  32'h0);
        check_eq("t3 midrst tvalid", 32'(o_tvalid), 32'h0);
        check_eq("t3 midrst busy",   32'(o_busy),   32'h0);
        mac_rst = 1'b0;

        // ---- Test 4: port_enable masking; clearing port 0 mid-frame
        model_clear();
        for (int p = 0; p < 4; p++) begin
            flen[p] = 3; left[p] = 1000;
        end
        port_en = 4'b1011;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            if (c >= 2) port_en = 4'b1010;
            step();
            check_eq($sformatf("t4 grant c%0d", c), 32'(o_grant), 32'(g4[c]));
            if (c == 3) begin
                check_eq("t4 p0 last tvalid", 32'(o_tvalid), 32'h1);
                check_eq("t4 p0 last tlast",  32'(o_tlast),  32'h1);
            end
        end

        // ---- Test 5: GAP_CYCLES=4 instance, two ports back to back
        model_clear();
        sel_b   = 1'b1;
        flen[0] = 2; left[0] = 1;
        flen[1] = 2; left[1] = 1;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            step();
            check_eq($sformatf("t5 grant c%0d", c),  32'(o_grant),  32'(g5[c]));
            check_eq($sformatf("t5 busy c%0d", c),   32'(o_busy),   32'(bz5[c]));
            check_eq($sformatf("t5 tvalid c%0d", c), 32'(o_tvalid), 32'(v5[c]));
        end
        check_eq("t5 tdata c8", o_tdata, 32'h1000_0000);
        sel_b = 1'b0;

`ifdef TX_ARB_STATS_EN
        // ---- Test 6: frame counters and clear priority
        model_clear();
        flen[0] = 1; left[0] = 3;
        flen[1] = 1; left[1] = 2;
        do_reset();
        check_eq("t6 cnt after reset", a_frame_count[31:0], 32'h0);
        for (int c = 0; c < 12; c++) step();
        check_eq("t6 cnt p0", 32'(a_frame_count[15:0]),  32'd3);
        check_eq("t6 cnt p1", 32'(a_frame_count[31:16]), 32'd2);
        check_eq("t6 cnt p2p3", a_frame_count[63:32], 32'h0);
        left[0] = 1;
        step();
        stats_clear = 1'b1;
        step();
        stats_clear = 1'b0;
        check_eq("t6 clear tlast seen", 32'(o_tvalid && o_tlast), 32'h1);
        check_eq("t6 clear lo a", a_frame_count[31:0],  32'h0);
        check_eq("t6 clear hi a", a_frame_count[63:32], 32'h0);
        check_eq("t6 clear lo b", b_frame_count[31:0],  32'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
